// File: rtl/gcd_job_master_if.sv
// gcd_job_master_if
//   Bundles the operand input stream, the result output stream and the
//   Avalon-MM master bus of gcd_job_master.
//
//   Signals:
//     in_valid/in_ready/in_a/in_b        operand pair stream (into the master)
//     out_valid/out_ready/out_result/out_err
//                                        result stream (out of the master)
//     avm_*                              zero-wait Avalon-MM bus to gcd_avalon
//
//   Modports:
//     master : the job master's view (drives in_ready, out_*, avm_* strobes)
//     slave  : the surrounding system's view (producer, consumer, GCD slave)
interface gcd_job_master_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_err;

    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        input  in_valid, in_a, in_b, out_ready, avm_readdata,
        output in_ready, out_valid, out_result, out_err,
               avm_address, avm_chipselect, avm_read, avm_write,
               avm_byteenable, avm_writedata
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready, avm_readdata,
        input  in_ready, out_valid, out_result, out_err,
               avm_address, avm_chipselect, avm_read, avm_write,
               avm_byteenable, avm_writedata
    );
endinterface

// File: rtl/gcd_job_master.sv
// gcd_job_master
//   Avalon-MM master that runs one GCD job at a time on the gcd_avalon slave:
//   accepts an operand pair, writes OP_A (word 0) then OP_B (word 1, which
//   starts the slave), waits POLL_DELAY idle cycles, polls STATUS (word 3,
//   bit 0) until done, reads RESULT (word 2) and offers it on the output
//   stream. An optional timeout aborts a job after TIMEOUT status reads.
//
//   Ports:
//     clock      system clock
//     reset      synchronous reset, active-low
//     bus        gcd_job_master_if.master (streams + Avalon-MM master)
//     busy       high whenever the FSM is not idle
//     jobs_done  number of results handed off (wraps), aborted jobs included
//
//   Parameters:
//     POLL_DELAY idle cycles between the OP_B write and the first STATUS
//                read, 2..15 (the slave's STATUS is stale for 2 cycles)
//     TIMEOUT    max STATUS reads per job, 0 disables the timeout
//     CNT_W      width of jobs_done
module gcd_job_master #(
    parameter int POLL_DELAY = 2,
    parameter int TIMEOUT    = 0,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    gcd_job_master_if.master     bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     jobs_done
);

    localparam int              PW           = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0]   TIMEOUT_W    = PW'(TIMEOUT);
    localparam logic [3:0]      POLL_DELAY_W = 4'(POLL_DELAY);

    localparam logic [1:0] ADDR_OP_A   = 2'd0;
    localparam logic [1:0] ADDR_OP_B   = 2'd1;
    localparam logic [1:0] ADDR_RESULT = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WAIT,
        S_POLL,
        S_RD_RES,
        S_OUT
    } state_t;

    state_t            state_q,  state_d;
    logic [31:0]       a_q,      a_d;
    logic [31:0]       b_q,      b_d;
    logic [3:0]        delay_q,  delay_d;
    logic [PW-1:0]     poll_q,   poll_d;
    logic [31:0]       result_q, result_d;
    logic              err_q,    err_d;
    logic [CNT_W-1:0]  jobs_q,   jobs_d;

    logic [PW-1:0]     poll_inc;

    assign poll_inc = poll_q + PW'(1);

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            delay_q  <= '0;
            poll_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            jobs_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            delay_q  <= delay_d;
            poll_q   <= poll_d;
            result_q <= result_d;
            err_q    <= err_d;
            jobs_q   <= jobs_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        delay_d  = delay_q;
        poll_d   = poll_q;
        result_d = result_q;
        err_d    = err_q;
        jobs_d   = jobs_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: begin
                state_d = S_WR_B;
            end
            S_WR_B: begin
                delay_d = POLL_DELAY_W;
                poll_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Leaves after exactly POLL_DELAY cycles spent here
                delay_d = delay_q - 4'd1;
                if (delay_q == 4'd1) begin
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                if (bus.avm_readdata[0]) begin
                    state_d = S_RD_RES;
                end else begin
                    poll_d = poll_inc;
                    if ((TIMEOUT != 0) && (poll_inc == TIMEOUT_W)) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = S_OUT;
                    end
                end
            end
            S_RD_RES: begin
                result_d = bus.avm_readdata;
                err_d    = 1'b0;
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    jobs_d  = jobs_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs; bus fields are zero except in the states that use them
    always_comb begin
        bus.in_ready       = (state_q == S_IDLE) && reset;
        bus.out_valid      = (state_q == S_OUT);
        bus.out_result     = result_q;
        bus.out_err        = err_q;
        busy               = (state_q != S_IDLE);
        jobs_done          = jobs_q;

        bus.avm_address    = 2'd0;
        bus.avm_chipselect = 1'b0;
        bus.avm_read       = 1'b0;
        bus.avm_write      = 1'b0;
        bus.avm_byteenable = 4'h0;
        bus.avm_writedata  = 32'h0;

        case (state_q)
            S_WR_A: begin
                bus.avm_chipselect = 1'b1;
                bus.avm_write      = 1'b1;
                bus.avm_address    = ADDR_OP_A;
                bus.avm_byteenable = 4'hF;
                bus.avm_writedata  = a_q;
            end
            S_WR_B: begin
                bus.avm_chipselect = 1'b1;
                bus.avm_write      = 1'b1;
                bus.avm_address    = ADDR_OP_B;
                bus.avm_byteenable = 4'hF;
                bus.avm_writedata  = b_q;
            end
            S_POLL: begin
                bus.avm_chipselect = 1'b1;
                bus.avm_read       = 1'b1;
                bus.avm_address    = ADDR_STATUS;
                bus.avm_byteenable = 4'hF;
            end
            S_RD_RES: begin
                bus.avm_chipselect = 1'b1;
                bus.avm_read       = 1'b1;
                bus.avm_address    = ADDR_RESULT;
                bus.avm_byteenable = 4'hF;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/gcd_job_master.md
Name: gcd_job_master

Overview:
- Avalon-MM master that drives the gcd_avalon slave.
- Accepts operand pairs on a valid/ready input stream and writes OP_A (word 0), then OP_B (word 1), which starts the slave.
- Polls STATUS (word 3, bit 0) until done, reads RESULT (word 2), and presents the result on a valid/ready output stream.
- Includes an optional timeout and a completed-job counter. It is the upstream stage feeding the GCD slave.

Parameters:
- POLL_DELAY, 2, idle bus cycles after the OP_B write before the first STATUS read; legal range 2..15.
- TIMEOUT, 0, maximum number of STATUS reads per job before abort; 0 disables the timeout.
- CNT_W, 16, width of the completed-job counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-low; the integration drives the slave's active-high reset from its inverse
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid and in_ready are both high
- in_a  in  32  operand A
- in_b  in  32  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_result  out  32  GCD result
- out_err  out  1  job aborted by timeout
- busy  out  1  high in every state except IDLE
- jobs_done  out  CNT_W  count of results handed off
- avm_address  out  2  slave word address
- avm_chipselect  out  1  slave chipselect
- avm_read  out  1  slave read strobe
- avm_write  out  1  slave write strobe
- avm_byteenable  out  4  slave byte enables
- avm_writedata  out  32  slave write data
- avm_readdata  in  32  slave read data, combinational; valid in the same cycle read is asserted

Behaviour:
- Reset values (sampled on the clock edge while reset is low):
  - FSM state IDLE.
  - in_ready=0 during reset, 1 after it is released.
  - out_valid=0, out_err=0, out_result=0, busy=0, jobs_done=0.
  - All avm_* outputs 0.
- Bus outputs default to 0 in every state that does not drive them. avm_byteenable=4'hF whenever chipselect=1.
- States and transitions:
  - IDLE: in_ready=1. On handshake, latch in_a/in_b into internal registers and go to WR_A.
  - WR_A: one cycle; chipselect=1, write=1, address=0, writedata=A. Next state WR_B.
  - WR_B: one cycle; write address=1, writedata=B. This is the single write that starts the slave. Load the delay counter with POLL_DELAY and go to WAIT.
  - WAIT: bus idle. Decrement the counter each cycle; go to POLL after POLL_DELAY cycles. The slave's STATUS stays stale for 2 cycles after the OP_B write, which is why POLL_DELAY is at least 2.
  - POLL: chipselect=1, read=1, address=3 every cycle, with readdata sampled at the clock edge.
    - readdata[0]=1: go to RD_RES.
    - Otherwise increment the poll counter (width $clog2(TIMEOUT+1), minimum 1). When TIMEOUT!=0 and the counter reaches TIMEOUT, set out_err=1, out_result=0, and go to OUT.
  - RD_RES: one cycle; read address=2, latch readdata into out_result, out_err=0. Next state OUT.
  - OUT: out_valid=1, with out_result/out_err held stable. On out_ready, increment jobs_done (wrap modulo 2^CNT_W) and go to IDLE. The counter increments on aborted jobs as well.
- Handshake rules:
  - in_ready is never high outside IDLE, so only one job is in flight.
  - out_valid stays high until accepted; no new input is accepted while a result is pending.
  - out_ready is ignored outside OUT.
- Write and read separation:
  - OP_B is never written on consecutive cycles, and write deasserts after WR_B, so the slave's write-edge detector sees exactly one edge per job.
  - read and write are never asserted together.
- Reset mid-operation: abandon immediately to IDLE with all outputs at reset values. The slave is reset by the same event.
- No waitrequest: the slave is zero-wait.

Test Plan:
- Reset low 3 cycles, then release -> in_ready=1, busy=0, all avm_* 0, jobs_done=0.
- Job A=12, B=18, out_ready=1 -> bus writes addr0=12 then addr1=18 on consecutive cycles, exactly POLL_DELAY idle cycles, STATUS reads until done -> out_result=6, out_err=0, jobs_done=1.
- Job A=7, B=0, POLL_DELAY=2, handshake in cycle i -> first status read shows 0, done seen on the third poll, out_valid first high in cycle i+9, out_result=7.
- Hold out_ready=0 for 5 cycles after out_valid -> out_result stable, in_ready=0, no bus activity; then out_ready=1 -> IDLE next cycle, jobs_done increments once.
- TIMEOUT=4, job A=32'hFFFFFFFF, B=1 -> exactly 4 STATUS reads, then out_err=1, out_result=0; next job 9, 6 -> out_result=3, out_err=0.
- Reset asserted while in POLL -> next cycle state IDLE, out_valid=0, avm_read=0; then job 100, 75 -> out_result=25.
